regbank_write_arbiter: RTL and testbench

- Shares the single write port of the register bank among NUM_REQ requesters (ALU writeback, load unit, CSR path, ...) using round-robin arbitration.
- Per-requester valid/ready handshake in; registered write-enable/select/data out, wired directly to the bank's write port.
- Out-of-range register selects are consumed, never written, and flagged as an error.

---
 rtl/regbank_pkg.sv | 13 +
 rtl/regbank_write_arbiter_if.sv | 34 +++
 rtl/regbank_write_arbiter_rr_grant.sv | 42 ++++
 rtl/regbank_write_arbiter.sv | 107 ++++++++++
 tb/tb_regbank_write_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// The fixed-priority build is selected with REGWR_ARB_FIXED_PRIO_EN.
package regbank_pkg;

  localparam int DEFAULT_NUM_REQ = 3;

  typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] req_idx_t;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_reg);
    return sel < num_reg;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Requester handshake plus bank write-port bundle for regbank_write_arbiter.
// Requesters and the bank drive the master side; the arbiter takes the slave side.
interface regbank_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG    = 6,
  parameter int NUM_REQ    = 3
);
  import regbank_pkg::*;

  localparam int SELECT_WIDTH = $clog2(NUM_REG);
  localparam int REQ_IDX_W    = $clog2(NUM_REQ);

  logic                            i_stall;
  logic [NUM_REQ-1:0]              i_req_valid;
  logic [NUM_REQ*SELECT_WIDTH-1:0] i_req_select;
  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data;
  logic [NUM_REQ-1:0]              o_req_ready;
  logic                            o_write_enable;
  logic [SELECT_WIDTH-1:0]         o_write_select;
  logic [DATA_WIDTH-1:0]           o_write_data;
  logic                            o_err_oob;
  logic [REQ_IDX_W-1:0]            o_last_grant;

  modport master (
    output i_stall, i_req_valid, i_req_select, i_req_data,
    input  o_req_ready, o_write_enable, o_write_select, o_write_data, o_err_oob, o_last_grant
  );

  modport slave (
    input  i_stall, i_req_valid, i_req_select, i_req_data,
    output o_req_ready, o_write_enable, o_write_select, o_write_data, o_err_oob, o_last_grant
  );

endinterface

// File: rtl/regbank_write_arbiter_rr_grant.sv
// Combinational rotating-priority grant: first valid at or above ptr_i, wrapping.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_grant
  import regbank_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int               k;
  logic [IDX_W-1:0] kk;

  // Scan from the farthest offset down so the nearest valid one overwrites last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    kk    = '0;
    if (en_i) begin
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        k = int'(ptr_i) + off;
        if (k >= NUM_REQ) k = k - NUM_REQ;
        kk = IDX_W'(k);
        if (valid_i[kk]) begin
          gnt_o     = '0;
          gnt_o[kk] = 1'b1;
          idx_o     = kk;
          any_o     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port; registered outputs.
// Define REGWR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer register).
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG    = 6,
  parameter int NUM_REQ    = DEFAULT_NUM_REQ
) (
  input  logic                   clk,
  input  logic                   rst,
  regbank_write_arbiter_if.slave bus
);

  localparam int SELECT_WIDTH = $clog2(NUM_REG);
  localparam int REQ_IDX_W    = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][SELECT_WIDTH-1:0] sel_arr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_arr;
  logic [NUM_REQ-1:0]                   gnt;
  logic [REQ_IDX_W-1:0]                 gnt_idx;
  logic [REQ_IDX_W-1:0]                 ptr;
  logic                                 acc;

  logic                    we_q, we_d;
  logic                    oob_q, oob_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [REQ_IDX_W-1:0]    last_q, last_d;

  assign sel_arr  = bus.i_req_select;
  assign data_arr = bus.i_req_data;

  // Grants are also blocked during reset so nothing is handshaken away unseen.
  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_grant (
    .valid_i (bus.i_req_valid),
    .ptr_i   (ptr),
    .en_i    (!bus.i_stall && !rst),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .any_o   (acc)
  );

`ifdef REGWR_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = (gnt_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + REQ_IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // Select/data hold when idle; only enable and error are pulses.
  always_comb begin
    we_d   = 1'b0;
    oob_d  = 1'b0;
    sel_d  = sel_q;
    data_d = data_q;
    last_d = last_q;
    if (acc) begin
      last_d = gnt_idx;
      if (sel_in_range(32'(sel_arr[gnt_idx]), NUM_REG)) begin
        we_d   = 1'b1;
        sel_d  = sel_arr[gnt_idx];
        data_d = data_arr[gnt_idx];
      end else begin
        oob_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      oob_q  <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
      last_q <= '0;
    end else begin
      we_q   <= we_d;
      oob_q  <= oob_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign bus.o_req_ready    = gnt;
  assign bus.o_write_enable = we_q;
  assign bus.o_err_oob      = oob_q;
  assign bus.o_write_select = sel_q;
  assign bus.o_write_data   = data_q;
  assign bus.o_last_grant   = last_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter: a queue-based reference model predicts
// grants and registered writes; a separate monitor pops and compares DUT outputs.
module tb_regbank_write_arbiter;

  localparam int DW   = 8;
  localparam int NREG = 6;
  localparam int NREQ = 3;
  localparam int SW   = 3;

  typedef struct {
    int cyc;
    bit we;
    bit oob;
    int sel;
    int dat;
    int last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t     expq[$];
  logic [NREQ-1:0] acc_m = '0;
  int       ptr_m = 0;
  int       hold_sel = 0, hold_dat = 0, hold_last = 0;
  logic [DW-1:0] bank_t[0:7];
  logic [DW-1:0] bank_m[0:7];

  logic            stall_r = 1'b0;
  logic [NREQ-1:0] valid_r = '0;
  logic [SW-1:0]   sel_r[NREQ];
  logic [DW-1:0]   data_r[NREQ];

  regbank_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REG(NREG), .NUM_REQ(NREQ)) bus ();

  regbank_write_arbiter #(.DATA_WIDTH(DW), .NUM_REG(NREG), .NUM_REQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int r = 0; r < 8; r++) begin
      bank_t[r] = '0;
      bank_m[r] = '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Bank behaves as a plain register file fed by the arbiter's write port.
  always @(posedge clk)
    if (!rst && bus.o_write_enable) bank_t[bus.o_write_select] <= bus.o_write_data;

  // Reference model: search for the first valid from the pointer, modulo NREQ.
  always @(negedge clk) begin
    int g;
    int k;
    int s;
    exp_t e;
    if (rst) begin
      ptr_m = 0;
      acc_m = '0;
      chk("ready_in_reset", 32'(bus.o_req_ready), 0);
    end else begin
      g = -1;
      if (!bus.i_stall)
        for (int o = 0; o < NREQ; o++) begin
          k = (ptr_m + o) % NREQ;
          if (g < 0 && bus.i_req_valid[k]) g = k;
        end
      acc_m = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("ready", 32'(bus.o_req_ready), 32'(acc_m));
      if (g >= 0) begin
        s      = int'(bus.i_req_select[g*SW +: SW]);
        e.cyc  = cyc + 1;
        e.we   = (s < NREG);
        e.oob  = (s >= NREG);
        e.sel  = s;
        e.dat  = int'(bus.i_req_data[g*DW +: DW]);
        e.last = g;
        expq.push_back(e);
`ifndef REGWR_ARB_FIXED_PRIO_EN
        ptr_m = (g + 1) % NREQ;
`endif
      end
    end
  end

  // Monitor: consumes one expectation per presented write or error pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expq.delete();
      hold_sel  = 0;
      hold_dat  = 0;
      hold_last = 0;
    end else if (bus.o_write_enable || bus.o_err_oob) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output at cycle %0d: we=%0b oob=%0b with nothing expected",
                 cyc, bus.o_write_enable, bus.o_err_oob);
      end else begin
        e = expq.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("write_enable", 32'(bus.o_write_enable), 32'(e.we));
        chk("err_oob", 32'(bus.o_err_oob), 32'(e.oob));
        chk("last_grant", 32'(bus.o_last_grant), e.last);
        hold_last = e.last;
        if (e.we) begin
          chk("write_select", 32'(bus.o_write_select), e.sel);
          chk("write_data", 32'(bus.o_write_data), e.dat);
          bank_m[e.sel] = DW'(e.dat);
          hold_sel = e.sel;
          hold_dat = e.dat;
        end
      end
    end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_output at cycle %0d: expected req%0d sel %0d data %0h, got none",
               cyc, e.last, e.sel, e.dat);
    end else begin
      chk("select_hold", 32'(bus.o_write_select), hold_sel);
      chk("data_hold", 32'(bus.o_write_data), hold_dat);
      chk("last_hold", 32'(bus.o_last_grant), hold_last);
    end
  end

  task automatic drive();
    bus.i_stall = stall_r;
    for (int k = 0; k < NREQ; k++) begin
      bus.i_req_valid[k]             = valid_r[k];
      bus.i_req_select[k*SW +: SW]   = sel_r[k];
      bus.i_req_data[k*DW +: DW]     = data_r[k];
    end
  endtask

  task automatic req(input int k, input int s, input int d);
    valid_r[k] = 1'b1;
    sel_r[k]   = SW'(s);
    data_r[k]  = DW'(d);
    drive();
  endtask

  // Advance one cycle and retire whatever the model saw accepted.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++)
      if (acc_m[k]) valid_r[k] = 1'b0;
    drive();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && valid_r != '0; i++) step();
    if (valid_r != '0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending valids %b", valid_r);
    end
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      sel_r[k]  = '0;
      data_r[k] = '0;
    end
    rst = 1'b1;
    req(0, 2, 'h11);
    req(1, 1, 'h22);
    req(2, 4, 'h33);
    repeat (2) @(negedge clk);
    chk("rst_write_enable", 32'(bus.o_write_enable), 0);
    chk("rst_write_select", 32'(bus.o_write_select), 0);
    chk("rst_write_data", 32'(bus.o_write_data), 0);
    chk("rst_err_oob", 32'(bus.o_err_oob), 0);
    chk("rst_last_grant", 32'(bus.o_last_grant), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All three requesters continuously valid: rotates 0,1,2,0,...
    for (int i = 0; i < 6; i++) begin
      step();
      if (!valid_r[0]) req(0, 2, 'h11);
      if (!valid_r[1]) req(1, 1, 'h22);
      if (!valid_r[2]) req(2, 4, 'h33);
    end
    drain();

    // Lone requester is granted every cycle.
    for (int i = 0; i < 3; i++) begin
      if (!valid_r[2]) req(2, 3, 'hAA);
      step();
    end
    drain();

    // Out-of-range select: consumed, flagged, not written.
    req(1, 7, 'hCC);
    repeat (3) step();

    // Stall freezes grants; nothing lost on release.
    stall_r = 1'b1;
    req(0, 5, 'h44);
    req(1, 0, 'h55);
    repeat (2) step();
    stall_r = 1'b0;
    drive();
    drain();
    repeat (2) step();

    // Reset while a write is registered: it must vanish immediately.
    req(0, 1, 'h66);
    req(1, 2, 'h77);
    req(2, 3, 'h88);
    step();
    chk("we_before_reset", 32'(bus.o_write_enable), 1);
    rst = 1'b1;
    #1;
    chk("we_async_reset", 32'(bus.o_write_enable), 0);
    repeat (2) step();
    if (!valid_r[0]) req(0, 1, 'h99);
    if (!valid_r[1]) req(1, 2, 'h77);
    if (!valid_r[2]) req(2, 3, 'h88);
    rst = 1'b0;
    drain();

    // Randomized traffic including out-of-range selects and stalls.
    for (int i = 0; i < 400; i++) begin
      stall_r = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < NREQ; k++)
        if (!valid_r[k] && $urandom_range(0, 1) == 1)
          req(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      drive();
      step();
    end
    stall_r = 1'b0;
    drive();
    drain();
    repeat (3) step();

    chk("queue_empty", expq.size(), 0);
    for (int r = 0; r < NREG; r++) chk($sformatf("bank_reg%0d", r), 32'(bank_t[r]), 32'(bank_m[r]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
